// File: rtl/decode_issue_if.sv
// Fetch/regfile/writeback/execute signal bundle for decode_issue.
// The DUT sits on the slave side; the surrounding pipeline is the master.
interface decode_issue_if #(
    parameter int DATA_W      = 8,
    parameter int REG_AW      = 3,
    parameter int STALL_CNT_W = 16
);
    logic                   in_valid;
    logic [15:0]            in_instr;
    logic                   in_ready;
    logic [REG_AW-1:0]      rf_raddr1;
    logic [REG_AW-1:0]      rf_raddr2;
    logic [DATA_W-1:0]      rf_rdata1;
    logic [DATA_W-1:0]      rf_rdata2;
    logic                   wb_valid;
    logic [REG_AW-1:0]      wb_rd;
    logic                   flush;
    logic                   ex_valid;
    logic                   ex_ready;
    logic [1:0]             ex_alu_op;
    logic [DATA_W-1:0]      ex_in_one;
    logic [DATA_W-1:0]      ex_in_two;
    logic [REG_AW-1:0]      ex_rd;
    logic                   illegal;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output in_valid, in_instr, rf_rdata1, rf_rdata2,
        output wb_valid, wb_rd, flush, ex_ready,
        input  in_ready, rf_raddr1, rf_raddr2, ex_valid,
        input  ex_alu_op, ex_in_one, ex_in_two, ex_rd,
        input  illegal, stall_cnt
    );

    modport slave (
        input  in_valid, in_instr, rf_rdata1, rf_rdata2,
        input  wb_valid, wb_rd, flush, ex_ready,
        output in_ready, rf_raddr1, rf_raddr2, ex_valid,
        output ex_alu_op, ex_in_one, ex_in_two, ex_rd,
        output illegal, stall_cnt
    );
endinterface

// File: rtl/decode_issue.sv
// Decode/issue stage: 16-bit decode, RAW scoreboard and a single
// registered issue slot feeding the execute ALU.
module decode_issue #(
    parameter int DATA_W      = 8,
    parameter int REG_AW      = 3,
    parameter int STALL_CNT_W = 16
) (
    input logic           clk,
    input logic           rst,
    decode_issue_if.slave io
);
    localparam int NREG = 2 ** REG_AW;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_PASS = 2'b11
    } alu_op_e;

    logic [3:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [DATA_W+7:0] imm_ext;

    logic              is_issue;
    logic              is_illegal;
    logic              use_rs1;
    logic              use_rs2;
    alu_op_e           dec_op;
    logic [DATA_W-1:0] dec_one;
    logic [DATA_W-1:0] dec_two;

    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic              hazard;
    logic              slot_free;
    logic              accept;
    logic              issue;
    logic              consumed;

    assign opcode  = io.in_instr[15:12];
    assign rd      = io.in_instr[11:9];
    assign rs1     = io.in_instr[8:6];
    assign rs2     = io.in_instr[5:3];
    assign imm_ext = {{DATA_W{1'b0}}, io.in_instr[7:0]};

    assign io.rf_raddr1 = rs1;
    assign io.rf_raddr2 = rs2;

    always_comb begin
        is_issue   = 1'b0;
        is_illegal = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        dec_op     = OP_ADD;
        dec_one    = io.rf_rdata1;
        dec_two    = io.rf_rdata2;
        unique case (opcode)
            4'b0000: ;
            4'b0001: begin
                is_issue = 1'b1;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                dec_op   = OP_ADD;
            end
            4'b0010: begin
                is_issue = 1'b1;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                dec_op   = OP_SUB;
            end
            4'b0011: begin
                is_issue = 1'b1;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                dec_op   = OP_MUL;
            end
            4'b0100: begin
                is_issue = 1'b1;
                use_rs1  = 1'b1;
                dec_op   = OP_PASS;
                dec_two  = '0;
            end
            4'b0101: begin
                is_issue = 1'b1;
                dec_op   = OP_PASS;
                dec_one  = imm_ext[DATA_W-1:0];
                dec_two  = '0;
            end
            default: is_illegal = 1'b1;
        endcase
    end

    // Registered busy only: a writeback this cycle does not unblock
    // a waiting reader until the following cycle.
    assign hazard    = io.in_valid &&
                       ((use_rs1 && busy[rs1]) || (use_rs2 && busy[rs2]));
    assign slot_free = !io.ex_valid || io.ex_ready;
    assign io.in_ready = slot_free && !hazard && !io.flush;
    assign accept    = io.in_valid && io.in_ready;
    assign issue     = accept && is_issue;
    assign consumed  = io.ex_valid && io.ex_ready;

    // A flushed, unconsumed op will never write back, so release its rd.
    always_comb begin
        busy_nxt = busy;
        if (io.wb_valid)
            busy_nxt[io.wb_rd] = 1'b0;
        if (io.flush && io.ex_valid && !io.ex_ready)
            busy_nxt[io.ex_rd] = 1'b0;
        if (issue)
            busy_nxt[rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= '0;
            io.ex_valid  <= 1'b0;
            io.ex_alu_op <= 2'b00;
            io.ex_in_one <= '0;
            io.ex_in_two <= '0;
            io.ex_rd     <= '0;
            io.illegal   <= 1'b0;
            io.stall_cnt <= '0;
        end else begin
            busy       <= busy_nxt;
            io.illegal <= accept && is_illegal;
            if (io.flush) begin
                io.ex_valid <= 1'b0;
            end else if (issue) begin
                io.ex_valid  <= 1'b1;
                io.ex_alu_op <= dec_op;
                io.ex_in_one <= dec_one;
                io.ex_in_two <= dec_two;
                io.ex_rd     <= rd;
            end else if (consumed) begin
                io.ex_valid <= 1'b0;
            end
            if (hazard && !io.flush && !(&io.stall_cnt))
                io.stall_cnt <= io.stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_decode_issue.sv
// Randomized bench for decode_issue against an opcode-table reference
// model with a scoreboard set and a queue of ops handed to execute.
module tb_decode_issue;
    logic clk = 1'b0;
    logic rst = 1'b1;

    decode_issue_if #(.DATA_W(8), .REG_AW(3), .STALL_CNT_W(16)) bus ();

    decode_issue #(.DATA_W(8), .REG_AW(3), .STALL_CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] rf [8];

    always_comb begin
        bus.rf_rdata1 = rf[bus.rf_raddr1];
        bus.rf_rdata2 = rf[bus.rf_raddr2];
    end

    typedef struct {
        bit         issue;
        bit         ill;
        bit         r1;
        bit         r2;
        bit         ldi;
        logic [1:0] op;
    } dec_t;

    int n_cmp = 0;
    int n_err = 0;

    bit         m_valid;
    logic [1:0] m_op;
    logic [7:0] m_one;
    logic [7:0] m_two;
    logic [2:0] m_rd;
    bit   [7:0] m_busy;
    bit         m_ill;
    int         m_stall;
    logic [2:0] exq[$];
    bit         shuffle;

    logic       r_v;
    logic       r_er;
    logic       r_fl;
    logic       r_wv;
    logic [2:0] r_wr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic dec_t decode(input logic [3:0] opc);
        dec_t d;
        d = '{issue: 0, ill: 0, r1: 0, r2: 0, ldi: 0, op: 2'b00};
        case (opc)
            4'h0: ;
            4'h1: d = '{issue: 1, ill: 0, r1: 1, r2: 1, ldi: 0, op: 2'b00};
            4'h2: d = '{issue: 1, ill: 0, r1: 1, r2: 1, ldi: 0, op: 2'b01};
            4'h3: d = '{issue: 1, ill: 0, r1: 1, r2: 1, ldi: 0, op: 2'b10};
            4'h4: d = '{issue: 1, ill: 0, r1: 1, r2: 0, ldi: 0, op: 2'b11};
            4'h5: d = '{issue: 1, ill: 0, r1: 0, r2: 0, ldi: 1, op: 2'b11};
            default: d.ill = 1;
        endcase
        return d;
    endfunction

    function automatic logic [15:0] enc(input logic [3:0] op,
            input logic [2:0] rd, input logic [2:0] a, input logic [2:0] b);
        return {op, rd, a, b, 3'b000};
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(7) != 0)
            w[15:12] = 4'($urandom_range(5));
        return w;
    endfunction

    task automatic model_clear();
        m_valid = 0;
        m_op    = 2'b00;
        m_one   = 8'h00;
        m_two   = 8'h00;
        m_rd    = 3'd0;
        m_busy  = '0;
        m_ill   = 0;
        m_stall = 0;
        exq.delete();
    endtask

    // Reset lands 2ns after a rising edge, i.e. mid-cycle.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_alu_op", bus.ex_alu_op, 0);
        chk("rst_in_one", bus.ex_in_one, 0);
        chk("rst_in_two", bus.ex_in_two, 0);
        chk("rst_rd", bus.ex_rd, 0);
        chk("rst_illegal", bus.illegal, 0);
        chk("rst_stall", bus.stall_cnt, 0);
        model_clear();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.ex_ready = 1'b0;
        bus.flush    = 1'b0;
        bus.wb_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input logic v, input logic [15:0] ins,
                        input logic er, input logic fl,
                        input logic wv, input logic [2:0] wr);
        dec_t       d;
        logic [2:0] s1, s2, rd;
        bit         haz, rdy, acc, cons;
        @(negedge clk);
        if (shuffle)
            rf[$urandom_range(7)] = 8'($urandom);
        bus.in_valid = v;
        bus.in_instr = ins;
        bus.ex_ready = er;
        bus.flush    = fl;
        bus.wb_valid = wv;
        bus.wb_rd    = wr;
        #1;
        s1   = ins[8:6];
        s2   = ins[5:3];
        rd   = ins[11:9];
        d    = decode(ins[15:12]);
        haz  = v && ((d.r1 && m_busy[s1]) || (d.r2 && m_busy[s2]));
        rdy  = (!m_valid || er) && !haz && !fl;
        acc  = v && rdy;
        cons = m_valid && er;
        chk("in_ready", bus.in_ready, rdy);
        chk("raddr1", bus.rf_raddr1, s1);
        chk("raddr2", bus.rf_raddr2, s2);
        chk("ex_valid", bus.ex_valid, m_valid);
        if (m_valid) begin
            chk("alu_op", bus.ex_alu_op, m_op);
            chk("in_one", bus.ex_in_one, m_one);
            chk("in_two", bus.ex_in_two, m_two);
            chk("ex_rd", bus.ex_rd, m_rd);
        end
        chk("illegal", bus.illegal, m_ill);
        chk("stall_cnt", bus.stall_cnt, m_stall);
        if (cons)
            exq.push_back(m_rd);
        if (wv)
            m_busy[wr] = 0;
        if (fl && m_valid && !er)
            m_busy[m_rd] = 0;
        if (fl) begin
            m_valid = 0;
        end else if (acc && d.issue) begin
            m_valid = 1;
            m_op    = d.op;
            m_one   = d.r1 ? rf[s1] : (d.ldi ? ins[7:0] : 8'h00);
            m_two   = d.r2 ? rf[s2] : 8'h00;
            m_rd    = rd;
            m_busy[rd] = 1;
        end else if (cons) begin
            m_valid = 0;
        end
        m_ill = acc && d.ill;
        if (haz && !fl && m_stall != 65535)
            m_stall++;
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            r_v  = ($urandom_range(3) != 0);
            r_er = ($urandom_range(3) != 0);
            r_fl = ($urandom_range(15) == 0);
            r_wv = 1'b0;
            r_wr = 3'd0;
            if (exq.size() > 0 && $urandom_range(2) == 0) begin
                r_wv = 1'b1;
                r_wr = exq.pop_front();
            end
            step(r_v, rand_instr(), r_er, r_fl, r_wv, r_wr);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_instr = 16'h0000;
        bus.ex_ready = 1'b0;
        bus.flush    = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_rd    = 3'd0;
        shuffle      = 0;
        for (int i = 0; i < 8; i++)
            rf[i] = 8'($urandom);
        rf[1] = 8'h05;
        rf[2] = 8'h03;
        model_clear();
        do_reset();

        // reset while ADD r3 sits in the slot with busy[3] set
        step(1, enc(4'h1, 3'd3, 3'd1, 3'd2), 1, 0, 0, 3'd0);
        do_reset();
        step(1, enc(4'h1, 3'd3, 3'd1, 3'd2), 1, 0, 0, 3'd0);
        step(1, 16'h58A7, 1, 0, 0, 3'd0);
        chk("add_op", bus.ex_alu_op, 2'b00);
        chk("add_one", bus.ex_in_one, 8'h05);
        chk("add_two", bus.ex_in_two, 8'h03);
        chk("add_rd", bus.ex_rd, 3'd3);

        // SUB r5,r3,r1 waits on r3 until the cycle after its writeback
        step(1, enc(4'h2, 3'd5, 3'd3, 3'd1), 1, 0, 0, 3'd0);
        chk("ldi_one", bus.ex_in_one, 8'hA7);
        chk("ldi_two", bus.ex_in_two, 8'h00);
        step(1, enc(4'h2, 3'd5, 3'd3, 3'd1), 1, 0, 0, 3'd0);
        step(1, enc(4'h2, 3'd5, 3'd3, 3'd1), 1, 0, 1, 3'd3);
        step(1, enc(4'h2, 3'd5, 3'd3, 3'd1), 1, 0, 0, 3'd0);
        step(0, 16'h0000, 1, 0, 1, 3'd4);
        chk("sub_op", bus.ex_alu_op, 2'b01);

        // MUL r2,r1,r1 held by backpressure
        step(1, enc(4'h3, 3'd2, 3'd1, 3'd1), 1, 0, 1, 3'd5);
        for (int i = 0; i < 4; i++)
            step(1, enc(4'h1, 3'd7, 3'd0, 3'd0), 0, 0, 0, 3'd0);
        step(1, enc(4'h1, 3'd7, 3'd0, 3'd0), 1, 0, 0, 3'd0);
        step(0, 16'h0000, 1, 0, 1, 3'd2);

        // MOV r6,r1 flushed out of a stalled slot
        step(1, enc(4'h4, 3'd6, 3'd1, 3'd0), 1, 0, 1, 3'd7);
        step(0, 16'h0000, 0, 0, 0, 3'd0);
        step(1, enc(4'h1, 3'd7, 3'd6, 3'd6), 0, 1, 0, 3'd0);
        step(1, enc(4'h1, 3'd7, 3'd6, 3'd6), 1, 0, 0, 3'd0);

        // illegal opcodes and NOP
        step(1, 16'h7123, 1, 0, 1, 3'd7);
        step(1, 16'hF456, 1, 0, 0, 3'd0);
        step(1, 16'h0000, 1, 0, 0, 3'd0);
        step(0, 16'h0000, 1, 0, 0, 3'd0);

        do_reset();
        shuffle = 1;
        rand_cycles(2000);
        do_reset();
        rand_cycles(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
